// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - command-driven LED pattern sequencer
//
// Steps through up to 16 pattern bits at TICK_HZ and repeats the pattern
// cmd_repeat times (0 = forever). Optional macro: LED_PWM_EN adds a duty
// input and an 8-bit PWM brightness gate on the LED outputs.
//
// Ports:
//   clk_12mhz    in            system clock
//   rst_n        in            synchronous reset, active low
//   cmd_valid    in            command present
//   cmd_ready    out           command can be accepted (IDLE only)
//   cmd_pattern  in  [15:0]    bit k = LED state during step k
//   cmd_len      in  [3:0]     last step index
//   cmd_repeat   in  [7:0]     repetitions, 0 = forever
//   cmd_mask     in  [N_LED]   LEDs driven when the step bit is 1
//   abort        in            stop the running pattern
//   duty         in  [7:0]     PWM duty (LED_PWM_EN only)
//   busy         out           high in RUN and DONE
//   done         out           one-cycle pulse when a finite pattern ends
//   led          out [N_LED]   LED drive, active high
module led_seq_ctrl #(
  parameter int CLK_HZ  = 12000000,
  parameter int TICK_HZ = 10,
  parameter int N_LED   = 5
) (
  input  logic             clk_12mhz,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [15:0]      cmd_pattern,
  input  logic [3:0]       cmd_len,
  input  logic [7:0]       cmd_repeat,
  input  logic [N_LED-1:0] cmd_mask,
  input  logic             abort,
`ifdef LED_PWM_EN
  input  logic [7:0]       duty,
`endif
  output logic             busy,
  output logic             done,
  output logic [N_LED-1:0] led
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV >= 2) ? $clog2(DIV) : 1;

  generate
    if (DIV < 2) begin : g_bad_div
      $error("led_seq_ctrl: CLK_HZ/TICK_HZ must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    tick_cnt;
  logic [15:0]      pat_q;
  logic [3:0]       len_q;
  logic [7:0]       rpt_q;
  logic [N_LED-1:0] mask_q;
  logic [3:0]       step;
  logic [7:0]       rep;
  logic [N_LED-1:0] led_reg;

  logic       tick;
  logic       accept;
  logic [3:0] step_nxt;
  logic [8:0] rep_nxt;
  logic       last_rep;

  assign tick      = (tick_cnt == CW'(DIV - 1));
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = cmd_valid && (state == S_IDLE);
  assign step_nxt  = step + 4'd1;
  // 9-bit so rep+1 compares cleanly against a repeat count of 255
  assign rep_nxt   = {1'b0, rep} + 9'd1;
  assign last_rep  = (rpt_q != 8'd0) && (rep_nxt == {1'b0, rpt_q});

  always_ff @(posedge clk_12mhz) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      pat_q    <= '0;
      len_q    <= '0;
      rpt_q    <= '0;
      mask_q   <= '0;
      step     <= '0;
      rep      <= '0;
      led_reg  <= '0;
      done     <= 1'b0;
    end else begin
      // Clearing on accept makes every step, including the first, DIV cycles long
      if (accept || tick) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end

      done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            pat_q   <= cmd_pattern;
            len_q   <= cmd_len;
            rpt_q   <= cmd_repeat;
            mask_q  <= cmd_mask;
            step    <= 4'd0;
            rep     <= 8'd0;
            led_reg <= cmd_pattern[0] ? cmd_mask : '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          // abort takes priority over a tick on the same edge
          if (abort) begin
            led_reg <= '0;
            state   <= S_IDLE;
          end else if (tick) begin
            if (step < len_q) begin
              step    <= step_nxt;
              led_reg <= pat_q[step_nxt] ? mask_q : '0;
            end else if (last_rep) begin
              led_reg <= '0;
              done    <= 1'b1;
              state   <= S_DONE;
            end else begin
              // rep may wrap in forever mode; only its low 8 bits matter there
              step    <= 4'd0;
              rep     <= rep_nxt[7:0];
              led_reg <= pat_q[0] ? mask_q : '0;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef LED_PWM_EN
  logic [7:0] pwm_cnt;
  logic       pwm_on;

  // Registered compare: over any 256 consecutive cycles pwm_on is high duty times
  always_ff @(posedge clk_12mhz) begin
    if (!rst_n) begin
      pwm_cnt <= 8'd0;
      pwm_on  <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      pwm_on  <= (pwm_cnt < duty);
    end
  end

  assign led = led_reg & {N_LED{pwm_on}};
`else
  assign led = led_reg;
`endif

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb/tb_led_seq_ctrl.sv - self-checking bench for led_seq_ctrl
module tb_led_seq_ctrl;

  localparam int CLK_HZ  = 100;
  localparam int TICK_HZ = 10;
  localparam int N_LED   = 5;
  localparam int DIV     = 10;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [15:0]      cmd_pattern;
  logic [3:0]       cmd_len;
  logic [7:0]       cmd_repeat;
  logic [N_LED-1:0] cmd_mask;
  logic             abort;
  logic             busy;
  logic             done;
  logic [N_LED-1:0] led;
`ifdef LED_PWM_EN
  logic [7:0]       duty;
`endif

  led_seq_ctrl #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .N_LED  (N_LED)
  ) dut (
    .clk_12mhz  (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_pattern(cmd_pattern),
    .cmd_len    (cmd_len),
    .cmd_repeat (cmd_repeat),
    .cmd_mask   (cmd_mask),
    .abort      (abort),
`ifdef LED_PWM_EN
    .duty       (duty),
`endif
    .busy       (busy),
    .done       (done),
    .led        (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      pat;
    logic [3:0]       len;
    logic [7:0]       rpt;
    logic [N_LED-1:0] mask;
    int               abort_k;    // abort driven while at cycle k (-1 = never)
    int               exp_done_k; // cycle after accept where done is high (-1 = none)
  } vec_t;

  int   n_chk;
  int   n_pass;
  int   since_rst;
  vec_t tbl [9];

  task automatic tick_edge();
    logic r;
    r = rst_n;
    @(posedge clk);
    #1;
    since_rst = r ? since_rst + 1 : 0;
  endtask

  // PWM gate is high after edge n (counted from the reset edge) when (n-1) mod 256 < duty
  function automatic logic gate_exp();
`ifdef LED_PWM_EN
    return (since_rst >= 1) && (((since_rst - 1) % 256) < int'(duty));
`else
    return 1'b1;
`endif
  endfunction

  // Behavioural view: at cycle k after accept the pattern is on step (k/DIV) mod (len+1)
  function automatic logic [N_LED-1:0] model_led(logic [15:0] pat, logic [3:0] len,
                                                 logic [N_LED-1:0] mask, int k);
    int s;
    s = (k / DIV) % (int'(len) + 1);
    return pat[s] ? mask : '0;
  endfunction

  task automatic check(input string name, input logic [N_LED-1:0] el, input logic ed,
                       input logic eb, input logic er);
    logic [N_LED-1:0] gl;
    gl = el & {N_LED{gate_exp()}};
    n_chk++;
    if (led === gl && done === ed && busy === eb && cmd_ready === er) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got led=%b done=%b busy=%b ready=%b, expected led=%b done=%b busy=%b ready=%b",
               name, led, done, busy, cmd_ready, gl, ed, eb, er);
    end
  endtask

  task automatic present(input vec_t v);
    cmd_pattern = v.pat;
    cmd_len     = v.len;
    cmd_repeat  = v.rpt;
    cmd_mask    = v.mask;
    cmd_valid   = 1'b1;
  endtask

  task automatic run_cmd(input string tag, input vec_t v, input bit hold_next, input vec_t nxt);
    int  total;
    bit  finite;
    int  done_seen;
    bit  ended;
    done_seen = -1;
    ended     = 1'b0;
    finite    = (v.rpt != 8'd0);
    total     = (int'(v.len) + 1) * int'(v.rpt) * DIV;
    present(v);
    tick_edge();
    if (hold_next) present(nxt);
    else cmd_valid = 1'b0;
    for (int k = 0; k < 6000; k++) begin
      if (v.abort_k >= 0 && k == v.abort_k + 1) begin
        check({tag, " aborted"}, '0, 1'b0, 1'b0, 1'b1);
        ended = 1'b1;
        break;
      end else if (finite && k == total) begin
        check({tag, " done"}, '0, 1'b1, 1'b1, 1'b0);
        done_seen = k;
      end else if (finite && k == total + 1) begin
        check({tag, " idle"}, '0, 1'b0, 1'b0, 1'b1);
        ended = 1'b1;
        break;
      end else begin
        check({tag, " run"}, model_led(v.pat, v.len, v.mask, k), 1'b0, 1'b1, 1'b0);
        if (done === 1'b1 && done_seen < 0) done_seen = k;
      end
      abort = (k == v.abort_k);
      tick_edge();
      abort = 1'b0;
    end
    if (!ended) begin
      n_chk++;
      $display("FAIL %s timeout: command never finished within 6000 cycles", tag);
    end
    n_chk++;
    if (done_seen == v.exp_done_k) n_pass++;
    else $display("FAIL %s done_cycle: got %0d expected %0d", tag, done_seen, v.exp_done_k);
  endtask

  initial begin
    vec_t none;
    vec_t v;
    n_chk       = 0;
    n_pass      = 0;
    since_rst   = 0;
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_pattern = '0;
    cmd_len     = '0;
    cmd_repeat  = '0;
    cmd_mask    = '0;
    abort       = 1'b0;
`ifdef LED_PWM_EN
    duty        = 8'd200;
`endif
    none = '{16'h0, 4'd0, 8'd1, '0, -1, -1};

    //           pat      len    rpt     mask      abort_k exp_done_k
    tbl[0] = '{16'h0005, 4'd3,  8'd1,   5'b00001, -1,     40};
    tbl[1] = '{16'h0001, 4'd0,  8'd3,   5'b10101, -1,     30};
    tbl[2] = '{16'hA5C3, 4'd15, 8'd2,   5'b11111, -1,     320};
    tbl[3] = '{16'h0006, 4'd2,  8'd0,   5'b00110, 519,    -1};
    tbl[4] = '{16'h0003, 4'd4,  8'd0,   5'b11000, 99,     -1};
    tbl[5] = '{16'h00F0, 4'd7,  8'd0,   5'b01010, 94,     -1};
    tbl[6] = '{16'h0002, 4'd1,  8'd255, 5'b10001, -1,     5100};
    tbl[7] = '{16'h000F, 4'd3,  8'd2,   5'b11111, 45,     -1};
    tbl[8] = '{16'h0001, 4'd0,  8'd0,   5'b00100, 2600,   -1};

    tick_edge();
    tick_edge();
    check("reset", '0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    tick_edge();
    check("idle after reset", '0, 1'b0, 1'b0, 1'b1);

    // abort in IDLE is ignored
    abort = 1'b1;
    tick_edge();
    abort = 1'b0;
    check("abort in idle", '0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 9; i++) begin
      run_cmd($sformatf("vec%0d", i), tbl[i], 1'b0, none);
    end

    // second command held on cmd_valid for the whole first command
    run_cmd("hold first", tbl[0], 1'b1, tbl[1]);
    run_cmd("hold second", tbl[1], 1'b0, none);

    // reset mid-RUN discards the pattern without a done pulse
    v = '{16'hFFFF, 4'd3, 8'd0, 5'b11111, -1, -1};
    present(v);
    tick_edge();
    cmd_valid = 1'b0;
    for (int k = 0; k < 25; k++) begin
      check("pre-reset run", 5'b11111, 1'b0, 1'b1, 1'b0);
      tick_edge();
    end
    rst_n = 1'b0;
    tick_edge();
    check("mid reset 1", '0, 1'b0, 1'b0, 1'b1);
    tick_edge();
    check("mid reset 2", '0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick_edge();
      check("post reset idle", '0, 1'b0, 1'b0, 1'b1);
    end

    // randomized commands against the model
    for (int i = 0; i < 12; i++) begin
      int total;
      v.pat  = 16'($urandom);
      v.len  = 4'($urandom_range(0, 15));
      v.rpt  = 8'($urandom_range(0, 3));
      v.mask = N_LED'($urandom);
      total  = (int'(v.len) + 1) * int'(v.rpt) * DIV;
      if (v.rpt == 8'd0) v.abort_k = int'($urandom_range(0, 300));
      else if ($urandom_range(0, 3) == 0) v.abort_k = int'($urandom_range(0, total - 1));
      else v.abort_k = -1;
      v.exp_done_k = (v.rpt != 8'd0 && v.abort_k < 0) ? total : -1;
      run_cmd($sformatf("rand%0d", i), v, 1'b0, none);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        abort = 1'($urandom);
        tick_edge();
        abort = 1'b0;
        check("rand gap idle", '0, 1'b0, 1'b0, 1'b1);
      end
    end

`ifdef LED_PWM_EN
    begin
      int on_cnt;
      v = '{16'hFFFF, 4'd15, 8'd0, 5'b11111, -1, -1};
      duty = 8'd64;
      present(v);
      tick_edge();
      cmd_valid = 1'b0;
      tick_edge();
      on_cnt = 0;
      for (int k = 0; k < 256; k++) begin
        if (led == 5'b11111) on_cnt++;
        tick_edge();
      end
      n_chk++;
      if (on_cnt == 64) n_pass++;
      else $display("FAIL pwm duty64: on cycles %0d expected 64", on_cnt);
      duty = 8'd0;
      tick_edge();
      tick_edge();
      on_cnt = 0;
      for (int k = 0; k < 256; k++) begin
        if (led != '0) on_cnt++;
        tick_edge();
      end
      n_chk++;
      if (on_cnt == 0) n_pass++;
      else $display("FAIL pwm duty0: on cycles %0d expected 0", on_cnt);
      abort = 1'b1;
      tick_edge();
      abort = 1'b0;
      check("pwm abort", '0, 1'b0, 1'b0, 1'b1);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
